// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : traffic_pkg
// Purpose : Shared state encoding, lamp patterns and a small helper for the
//           N-way traffic-light controller.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Controller phases
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_CLEAR  = 3'd0;
  localparam logic [2:0] ST_GREEN  = 3'd1;
  localparam logic [2:0] ST_YELLOW = 3'd2;
  localparam logic [2:0] ST_WALK   = 3'd3;
  localparam logic [2:0] ST_FLASH  = 3'd4;

  // Lamp patterns, ordered {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Purpose : Free-running divider producing a one-cycle strobe every TICK_DIV
//           clocks. The strobe is registered and high exactly while the
//           internal count equals TICK_DIV-1.
// Ports   : clk  - system clock
//           rst  - synchronous active-high reset
//           tick - one-cycle strobe
// Rev     : 1.0  initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_tick;

  always_comb begin
    w_count_next = (r_count == LAST) ? '0 : r_count + 1'b1;
  end

  // The strobe is registered from the next count so it lines up with the
  // count register itself, without adding a cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tick  <= (w_count_next == LAST);
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : traffic_light_ctrl
// Purpose : N-way traffic-light controller with tick-based phase timers,
//           vehicle-presence skipping, latched pedestrian walk phase and a
//           night flashing-yellow mode.
// Ports   : clk         - system clock
//           rst         - synchronous active-high reset
//           night_mode  - level, request flashing-yellow operation
//           ped_req     - pedestrian request (pulse or level)
//           car_present - bit i set: vehicle waiting on approach i
//           lights      - approach i at [3i+2:3i] = {red, yellow, green}
//           walk        - pedestrian walk lamp
//           active_way  - approach currently or last served
//           tick        - one-cycle prescaler strobe
// Rev     : 1.0  initial release
// ============================================================================
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int N_WAY    = 2,
  parameter int TICK_DIV = 100000000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int CLEAR_T  = 1,
  parameter int WALK_T   = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       night_mode,
  input  logic                                       ped_req,
  input  logic [N_WAY-1:0]                           car_present,
  output logic [3*N_WAY-1:0]                         lights,
  output logic                                       walk,
  output logic [((N_WAY > 1) ? $clog2(N_WAY) : 1)-1:0] active_way,
  output logic                                       tick
);

  localparam int AW    = (N_WAY > 1) ? $clog2(N_WAY) : 1;
  localparam int MAX_T = max_int(max_int(GREEN_T, YELLOW_T), max_int(CLEAR_T, WALK_T));
  // Timer only ever holds 0..T-1
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] CLEAR_LAST  = TW'(CLEAR_T - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_T - 1);

  logic          w_tick;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [AW-1:0] r_way;
  logic          r_flash;
  logic          r_ped;

  logic          w_phase_last;
  logic [AW-1:0] w_next_way;
  logic [AW-1:0] w_cand;
  logic          w_found;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Last tick of the current timed phase
  always_comb begin
    case (r_state)
      ST_CLEAR:  w_phase_last = (r_timer == CLEAR_LAST);
      ST_GREEN:  w_phase_last = (r_timer == GREEN_LAST);
      ST_YELLOW: w_phase_last = (r_timer == YELLOW_LAST);
      ST_WALK:   w_phase_last = (r_timer == WALK_LAST);
      default:   w_phase_last = 1'b0;
    endcase
  end

  // Next approach: first waiting vehicle scanning cyclically from
  // r_way+1 (r_way itself is visited last). With no vehicles anywhere,
  // fall back to plain rotation.
  always_comb begin
    w_found    = 1'b0;
    w_cand     = '0;
    w_next_way = AW'((int'(r_way) + 1) % N_WAY);
    for (int k = 1; k <= N_WAY; k++) begin
      w_cand = AW'((int'(r_way) + k) % N_WAY);
      if (!w_found && car_present[w_cand]) begin
        w_found    = 1'b1;
        w_next_way = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_timer <= '0;
      r_way   <= AW'(N_WAY - 1);
      r_flash <= 1'b0;
      r_ped   <= 1'b0;
    end else begin
      if (ped_req && (r_state != ST_WALK)) begin
        r_ped <= 1'b1;
      end
      if (w_tick) begin
        case (r_state)
          ST_CLEAR: begin
            if (w_phase_last) begin
              r_timer <= '0;
              if (night_mode) begin
                r_state <= ST_FLASH;
                r_flash <= 1'b1;
              end else if (r_ped) begin
                // Clearing here wins over a request arriving on this edge
                r_state <= ST_WALK;
                r_ped   <= 1'b0;
              end else begin
                r_state <= ST_GREEN;
                r_way   <= w_next_way;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_GREEN: begin
            if (night_mode || w_phase_last) begin
              r_state <= ST_YELLOW;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_YELLOW, ST_WALK: begin
            if (w_phase_last) begin
              r_state <= ST_CLEAR;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_FLASH: begin
            if (!night_mode) begin
              r_state <= ST_CLEAR;
              r_timer <= '0;
              r_flash <= 1'b0;
            end else begin
              r_flash <= ~r_flash;
            end
          end
          default: begin
            r_state <= ST_CLEAR;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < N_WAY; i++) begin
      case (r_state)
        ST_GREEN:  lights[3*i +: 3] = (r_way == AW'(i)) ? LAMP_GRN : LAMP_RED;
        ST_YELLOW: lights[3*i +: 3] = (r_way == AW'(i)) ? LAMP_YEL : LAMP_RED;
        ST_FLASH:  lights[3*i +: 3] = r_flash ? LAMP_YEL : LAMP_OFF;
        default:   lights[3*i +: 3] = LAMP_RED;
      endcase
    end
  end

  assign walk       = (r_state == ST_WALK);
  assign active_way = r_way;
  assign tick       = w_tick;

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Parametrised N-way traffic-light controller; successor to the fixed two-way controller.
- Adds configurable phase durations, a free-running 1 s tick prescaler, vehicle-presence skipping, a latched pedestrian walk phase and a night flashing-yellow mode.
- Top-level block driving intersection lamp outputs; every phase timer counts prescaler ticks, not raw clocks.

Parameters:
- N_WAY, 2, number of approaches (2..4).
- TICK_DIV, 100000000, clk cycles per tick (1 s at 100 MHz); must be ≥1.
- GREEN_T, 10, ticks per green phase (≥1).
- YELLOW_T, 3, ticks per yellow phase (≥1).
- CLEAR_T, 1, ticks per all-red clearance (≥1).
- WALK_T, 8, ticks per pedestrian walk phase (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- night_mode  in  1  level; request flashing-yellow operation.
- ped_req  in  1  pedestrian request; single-cycle pulse or level.
- car_present  in  N_WAY  bit i=1: vehicle waiting on approach i.
- lights  out  3*N_WAY  approach i at [3i+2:3i] = {red, yellow, green}.
- walk  out  1  pedestrian walk lamp.
- active_way  out  max(1,$clog2(N_WAY))  approach currently or last served.
- tick  out  1  one-cycle prescaler strobe.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk, and overrides all other inputs in the same cycle.
- Reset values:
  - state CLEAR; phase timer 0; prescaler 0; ped_pending 0; flash 0.
  - active_way=N_WAY-1, so the first search starts at approach 0.
  - lights = all 3'b100; walk=0; tick=0.
- Prescaler: counts 0..TICK_DIV-1 and is free-running. tick=1 in the cycle where count==TICK_DIV-1, registered, no extra latency. TICK_DIV=1 gives tick every cycle.
- Phase timer: increments on tick. A phase of length T ends on the tick where timer==T-1; the new state and outputs appear the next cycle, and the timer clears.
- States and outputs:
  - CLEAR: all red.
  - GREEN: approach active_way =001, others 100.
  - YELLOW: approach active_way =010, others 100.
  - WALK: all red, walk=1.
  - FLASH: every approach ={0,flash,0}, walk=0.
- Transitions at phase end:
  - CLEAR → FLASH if night_mode; else → WALK if ped_pending; else → GREEN at the next approach.
  - Next approach: first index j scanning cyclically from active_way+1 with car_present[j]=1. If no bit is set, use active_way+1 mod N_WAY (fixed-time fallback). active_way updates on GREEN entry.
  - GREEN → YELLOW after GREEN_T.
  - Early exit: night_mode=1 sampled on any tick during GREEN forces YELLOW on the next cycle.
  - YELLOW → CLEAR after YELLOW_T. Always via CLEAR, never directly to FLASH.
  - WALK → CLEAR after WALK_T. active_way is unchanged, so rotation resumes where it left off.
  - FLASH: flash toggles on every tick; entered with flash=1. Exit when night_mode=0 is sampled on a tick → CLEAR, timer 0.
- Pedestrian handling:
  - ped_pending sets on ped_req=1 in any state except WALK; ped_req during WALK is ignored.
  - ped_pending clears on WALK entry and is preserved through FLASH.
- Priority at CLEAR end: night_mode > ped_pending > green rotation.
- Invariants:
  - Never more than one approach non-red.
  - Green never follows green without YELLOW then CLEAR.
  - walk=1 only while all approaches are red.
- Mid-operation rst: returns to the reset state on the next edge, whatever the phase.

Decomposition:
- Package traffic_pkg:
  - state encoding {CLEAR, GREEN, YELLOW, WALK, FLASH};
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
- Sub-module tick_prescaler (params TICK_DIV; ports clk, rst, tick).
- Next-approach scan stays inline in traffic_light_ctrl.

Test Plan:
Common bench parameters: N_WAY=3, TICK_DIV=4, GREEN_T=3, YELLOW_T=2, CLEAR_T=1, WALK_T=2; rst released so cycle 0 is the first non-reset edge.
1. car_present=3'b111 -> ticks at cycles 3,7,11,…
   - way0 green (001) from cycle 4;
   - yellow from 16;
   - all-red from 24;
   - way1 green from 28;
   - active_way=1.
2. car_present=3'b101 -> rotation 0→2→0; way1 is never green.
   - car_present=0 -> fixed rotation 0→1→2.
3. ped_req pulse at cycle 6 during way0 green -> way0 yellow at 16, CLEAR at 24, walk=1 with all red at 28–35, CLEAR, then way1 green.
   - A ped_req during WALK produces no second walk.
4. night_mode=1 at cycle 5 (way0 green) -> yellow from cycle 8, CLEAR, then FLASH; yellow bits toggle 1,0,1 per tick.
   - Dropping night_mode -> CLEAR then green resumes at way1.
5. rst asserted for one cycle mid-YELLOW -> next cycle: all 100, walk=0, active_way=2, prescaler restarts (next tick 4 cycles later).
6. Throughout all runs, a checker asserts the invariants: ≤1 non-red approach, and walk implies all red.
